// File: rtl/axi_pkg.sv
// Shared definitions for the AXI3 SRAM responder.
// Holds the bus widths, the response and burst codes, the read and write
// FSM state enums, and the per-beat address step helper.
package axi_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    // Address of the following beat. The memory is 32 bits wide, so sizes
    // above 4 bytes step like size 2. FIXED stays on one address. WRAP and
    // the reserved code step like INCR.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0]        size,
                                                    input logic [1:0]        burst);
        logic [ADDR_W-1:0] step;
        step = (size >= 3'd2) ? ADDR_W'(4) : (ADDR_W'(1) << size);
        return (burst == FIXED) ? addr : addr + step;
    endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// DEPTH x 32-bit word array for the AXI SRAM responder.
// Ports:
//   clock        write clock
//   we, waddr    write enable and word index
//   wdata, wstrb write data and byte enables (wstrb[i] covers wdata[8i+7:8i])
//   raddr, rdata asynchronous read port
// A write and a read of the same word in one cycle return the old word.
// The new word is visible after the clock edge.
module axi_sram_mem
    import axi_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[raddr];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by an internal word-addressed SRAM.
// The read and write channels are independent. Each channel allows one
// outstanding transaction. Bursts can be INCR or FIXED with up to 16 beats.
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   io_axi_ar_* / r_*    read address / read data channels
//   io_axi_aw_* / w_* / b_*  write address / write data / write response
// The lock, cache and prot fields are ignored. w_last and w_id are ignored:
// a write burst ends when the beat count reaches len.
// Optional build macro AXI_SRAM_OOR_ERR_EN: beats outside
// [BASE_ADDR, BASE_ADDR + 4*DEPTH) return SLVERR. Such a read beat returns
// data 0. Such a write beat is dropped. When the macro is undefined,
// addresses wrap modulo DEPTH and the response is always OKAY.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int          DEPTH     = 16384,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ID_W-1:0]   io_axi_ar_bits_id,
    input  logic [ADDR_W-1:0] io_axi_ar_bits_addr,
    input  logic [3:0]        io_axi_ar_bits_len,
    input  logic [2:0]        io_axi_ar_bits_size,
    input  logic [1:0]        io_axi_ar_bits_burst,
    input  logic [1:0]        io_axi_ar_bits_lock,
    input  logic [3:0]        io_axi_ar_bits_cache,
    input  logic [2:0]        io_axi_ar_bits_prot,
    input  logic              io_axi_ar_valid,
    output logic              io_axi_ar_ready,
    output logic [ID_W-1:0]   io_axi_r_bits_id,
    output logic [DATA_W-1:0] io_axi_r_bits_data,
    output logic [1:0]        io_axi_r_bits_resp,
    output logic              io_axi_r_bits_last,
    output logic              io_axi_r_valid,
    input  logic              io_axi_r_ready,
    input  logic [ID_W-1:0]   io_axi_aw_bits_id,
    input  logic [ADDR_W-1:0] io_axi_aw_bits_addr,
    input  logic [3:0]        io_axi_aw_bits_len,
    input  logic [2:0]        io_axi_aw_bits_size,
    input  logic [1:0]        io_axi_aw_bits_burst,
    input  logic [1:0]        io_axi_aw_bits_lock,
    input  logic [3:0]        io_axi_aw_bits_cache,
    input  logic [2:0]        io_axi_aw_bits_prot,
    input  logic              io_axi_aw_valid,
    output logic              io_axi_aw_ready,
    input  logic [ID_W-1:0]   io_axi_w_bits_id,
    input  logic [DATA_W-1:0] io_axi_w_bits_data,
    input  logic [STRB_W-1:0] io_axi_w_bits_strb,
    input  logic              io_axi_w_bits_last,
    input  logic              io_axi_w_valid,
    output logic              io_axi_w_ready,
    output logic [ID_W-1:0]   io_axi_b_bits_id,
    output logic [1:0]        io_axi_b_bits_resp,
    output logic              io_axi_b_valid,
    input  logic              io_axi_b_ready
);

    localparam int AW = $clog2(DEPTH);

    // ---------------- read channel state ----------------
    rd_state_e         rstate_q, rstate_d;
    logic              ar_ready_q, ar_ready_d;
    logic              r_valid_q, r_valid_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [1:0]        r_resp_q, r_resp_d;
    logic              r_last_q, r_last_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [3:0]        rlen_q, rlen_d;
    logic [3:0]        rbeat_q, rbeat_d;
    logic [2:0]        rsize_q, rsize_d;
    logic [1:0]        rburst_q, rburst_d;

    // ---------------- write channel state ----------------
    wr_state_e         wstate_q, wstate_d;
    logic              aw_ready_q, aw_ready_d;
    logic              w_ready_q, w_ready_d;
    logic              b_valid_q, b_valid_d;
    logic [ID_W-1:0]   b_id_q, b_id_d;
    logic [1:0]        b_resp_q, b_resp_d;
    logic [ID_W-1:0]   wid_q, wid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [3:0]        wlen_q, wlen_d;
    logic [3:0]        wbeat_q, wbeat_d;
    logic [2:0]        wsize_q, wsize_d;
    logic [1:0]        wburst_q, wburst_d;
    logic              werr_q, werr_d;

    // ---------------- memory ----------------
    logic [ADDR_W-1:0] rd_addr, rd_off, wr_off;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd_oor, wr_oor, mem_we;
    logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign ar_hs = io_axi_ar_valid & ar_ready_q;
    assign r_hs  = r_valid_q & io_axi_r_ready;
    assign aw_hs = io_axi_aw_valid & aw_ready_q;
    assign w_hs  = io_axi_w_valid & w_ready_q;
    assign b_hs  = b_valid_q & io_axi_b_ready;

    // The R data is registered. The word loaded next is read from the AR
    // address while idle, and from the next beat address while in a burst.
    // With this, r_data stays stable during a stall, and a write to the same
    // word in the load cycle is not seen until the next beat.
    assign rd_addr = (rstate_q == R_IDLE) ? io_axi_ar_bits_addr
                                          : next_addr(raddr_q, rsize_q, rburst_q);
    assign rd_off  = rd_addr - BASE_ADDR;
    assign wr_off  = waddr_q - BASE_ADDR;

`ifdef AXI_SRAM_OOR_ERR_EN
    localparam logic [63:0] RANGE_BYTES = 64'(DEPTH) << 2;
    assign rd_oor = (rd_addr < BASE_ADDR) || ({32'b0, rd_off} >= RANGE_BYTES);
    assign wr_oor = (waddr_q < BASE_ADDR) || ({32'b0, wr_off} >= RANGE_BYTES);
`else
    assign rd_oor = 1'b0;
    assign wr_oor = 1'b0;
`endif

    // A write in the same cycle as reset is blocked. Beats already
    // committed before the reset stay in memory.
    assign mem_we = w_hs & ~wr_oor & ~reset;

    axi_sram_mem #(.DEPTH(DEPTH)) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (wr_off[AW+1:2]),
        .wdata (io_axi_w_bits_data),
        .wstrb (io_axi_w_bits_strb),
        .raddr (rd_off[AW+1:2]),
        .rdata (mem_rdata)
    );

    // ---------------- read FSM ----------------
    always_comb begin
        rstate_d   = rstate_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        r_id_d     = r_id_q;
        r_resp_d   = r_resp_q;
        r_last_d   = r_last_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rbeat_d    = rbeat_q;
        rsize_d    = rsize_q;
        rburst_d   = rburst_q;
        case (rstate_q)
            R_IDLE: begin
                ar_ready_d = 1'b1;
                if (ar_hs) begin
                    rstate_d   = R_BURST;
                    ar_ready_d = 1'b0;
                    r_valid_d  = 1'b1;
                    raddr_d    = io_axi_ar_bits_addr;
                    rlen_d     = io_axi_ar_bits_len;
                    rsize_d    = io_axi_ar_bits_size;
                    rburst_d   = io_axi_ar_bits_burst;
                    rbeat_d    = 4'd0;
                    r_id_d     = io_axi_ar_bits_id;
                    r_last_d   = (io_axi_ar_bits_len == 4'd0);
                    r_data_d   = rd_oor ? '0 : mem_rdata;
                    r_resp_d   = rd_oor ? SLVERR : OKAY;
                end
            end
            R_BURST: begin
                if (r_hs) begin
                    if (r_last_q) begin
                        rstate_d   = R_IDLE;
                        r_valid_d  = 1'b0;
                        r_last_d   = 1'b0;
                        ar_ready_d = 1'b1;
                    end else begin
                        rbeat_d  = rbeat_q + 4'd1;
                        raddr_d  = rd_addr;
                        r_last_d = ((rbeat_q + 4'd1) == rlen_q);
                        r_data_d = rd_oor ? '0 : mem_rdata;
                        r_resp_d = rd_oor ? SLVERR : OKAY;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rstate_q   <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_id_q     <= '0;
            r_resp_q   <= OKAY;
            r_last_q   <= 1'b0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rbeat_q    <= '0;
            rsize_q    <= '0;
            rburst_q   <= '0;
        end else begin
            rstate_q   <= rstate_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_id_q     <= r_id_d;
            r_resp_q   <= r_resp_d;
            r_last_q   <= r_last_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rbeat_q    <= rbeat_d;
            rsize_q    <= rsize_d;
            rburst_q   <= rburst_d;
        end
    end

    // ---------------- write FSM ----------------
    always_comb begin
        wstate_d   = wstate_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        b_id_d     = b_id_q;
        b_resp_d   = b_resp_q;
        wid_d      = wid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wbeat_d    = wbeat_q;
        wsize_d    = wsize_q;
        wburst_d   = wburst_q;
        werr_d     = werr_q;
        case (wstate_q)
            W_IDLE: begin
                aw_ready_d = 1'b1;
                if (aw_hs) begin
                    wstate_d   = W_DATA;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    wid_d      = io_axi_aw_bits_id;
                    waddr_d    = io_axi_aw_bits_addr;
                    wlen_d     = io_axi_aw_bits_len;
                    wsize_d    = io_axi_aw_bits_size;
                    wburst_d   = io_axi_aw_bits_burst;
                    wbeat_d    = 4'd0;
                    werr_d     = 1'b0;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (wbeat_q == wlen_q) begin
                        wstate_d  = W_RESP;
                        w_ready_d = 1'b0;
                        b_valid_d = 1'b1;
                        b_id_d    = wid_q;
                        b_resp_d  = (werr_q | wr_oor) ? SLVERR : OKAY;
                    end else begin
                        wbeat_d = wbeat_q + 4'd1;
                        waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
                        werr_d  = werr_q | wr_oor;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    wstate_d   = W_IDLE;
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wstate_q   <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= OKAY;
            wid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wbeat_q    <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
            werr_q     <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_id_q     <= b_id_d;
            b_resp_q   <= b_resp_d;
            wid_q      <= wid_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wbeat_q    <= wbeat_d;
            wsize_q    <= wsize_d;
            wburst_q   <= wburst_d;
            werr_q     <= werr_d;
        end
    end

    assign io_axi_ar_ready    = ar_ready_q;
    assign io_axi_r_valid     = r_valid_q;
    assign io_axi_r_bits_data = r_data_q;
    assign io_axi_r_bits_id   = r_id_q;
    assign io_axi_r_bits_resp = r_resp_q;
    assign io_axi_r_bits_last = r_last_q;
    assign io_axi_aw_ready    = aw_ready_q;
    assign io_axi_w_ready     = w_ready_q;
    assign io_axi_b_valid     = b_valid_q;
    assign io_axi_b_bits_id   = b_id_q;
    assign io_axi_b_bits_resp = b_resp_q;

    // These fields are accepted but have no effect on behaviour.
    logic unused_sigs;
    assign unused_sigs = ^{io_axi_ar_bits_lock, io_axi_ar_bits_cache, io_axi_ar_bits_prot,
                           io_axi_aw_bits_lock, io_axi_aw_bits_cache, io_axi_aw_bits_prot,
                           io_axi_w_bits_id, io_axi_w_bits_last, rd_off, wr_off};

endmodule
